pwm_multi: RTL

Parametrised per-channel PWM generator for the transducer output stage, a successor to the fixed 8-bit `pwm` stage. It sits after `silencer_pwe_selector` and drives `PWM_OUT`. It accepts a streamed frame of `DEPTH` pulse-width/phase pairs into a shadow bank and commits the frame atomically on `UPDATE`. It generalises counter width and adds centre-aligned mode, full-on pulse width, and partial-frame detection.

---
 rtl/pwm_multi_if.sv | 26 ++
 rtl/pwm_multi.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pwm_multi_if.sv
// Frame-stream and PWM output bundle for pwm_multi.
// The master side drives the carrier and frame beats; the slave side returns the outputs.
interface pwm_multi_if #(
    parameter int unsigned DEPTH = 249,
    parameter int unsigned W     = 8
);
    logic [W-1:0]     time_cnt;
    logic             update;
    logic             mode;
    logic             din_valid;
    logic [W:0]       pulse_width;
    logic [W-1:0]     phase;
    logic [DEPTH-1:0] pwm_out;
    logic             dout_valid;
    logic             load_err;

    modport master (
        output time_cnt, update, mode, din_valid, pulse_width, phase,
        input  pwm_out, dout_valid, load_err
    );

    modport slave (
        input  time_cnt, update, mode, din_valid, pulse_width, phase,
        output pwm_out, dout_valid, load_err
    );
endinterface

// File: rtl/pwm_multi.sv
// Per-channel PWM generator: frames stream into a shadow bank and commit atomically on update.
// Edges are precomputed at load time so the output stage only compares against the carrier.
module pwm_multi #(
    parameter int unsigned DEPTH = 249,
    parameter int unsigned W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_multi_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW    = W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [W:0]       P_MAX    = PW'(1) << W;

    typedef struct packed {
        logic         full;
        logic         zero;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } edges_t;

    localparam edges_t EDGES_RST = '{full: 1'b0, zero: 1'b1, rise: '0, fall: '0};

    logic [IDX_W-1:0] load_idx, load_idx_n;
    logic             shadow_full, shadow_full_n;
    logic             shadow_mode;
    edges_t           shadow [DEPTH];
    edges_t           active [DEPTH];
    logic [DEPTH-1:0] pwm_q, pwm_c;
    logic             dout_valid_q, load_err_q;

    logic [W:0]       p_sat;
    logic [W:0]       rise_w, fall_w;
    logic             beat_mode;
    edges_t           beat;
    logic             last_beat, commit, frame_err;

    // Edge computation for the incoming beat; mode comes live on beat 0, latched after.
    always_comb begin
        beat      = EDGES_RST;
        p_sat     = (bus.pulse_width > P_MAX) ? P_MAX : bus.pulse_width;
        beat_mode = (load_idx == '0) ? bus.mode : shadow_mode;
        rise_w    = {1'b0, bus.phase} - {1'b0, p_sat[W:1]};
        beat.rise = beat_mode ? W'(rise_w) : bus.phase;
        fall_w    = {1'b0, beat.rise} + p_sat;
        beat.fall = W'(fall_w);
        beat.full = (p_sat == P_MAX);
        beat.zero = (p_sat == '0);
    end

    // Frame sequencing: beat counting, commit and partial-frame detection.
    always_comb begin
        load_idx_n    = load_idx;
        shadow_full_n = shadow_full;
        last_beat     = bus.din_valid && (load_idx == LAST_IDX);
        commit        = bus.update && (shadow_full || last_beat);
        frame_err     = bus.update && !commit && ((load_idx != '0) || bus.din_valid);

        if (bus.din_valid) begin
            load_idx_n = last_beat ? '0 : load_idx + IDX_W'(1);
            if (load_idx == '0) begin
                shadow_full_n = 1'b0;
            end
            if (last_beat) begin
                shadow_full_n = 1'b1;
            end
        end

        if (commit) begin
            shadow_full_n = 1'b0;
        end else if (bus.update) begin
            load_idx_n    = '0;
            shadow_full_n = 1'b0;
        end
    end

    // Carrier comparison against the active bank.
    always_comb begin
        pwm_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (active[i].zero) begin
                pwm_c[i] = 1'b0;
            end else if (active[i].full) begin
                pwm_c[i] = 1'b1;
            end else if (active[i].rise < active[i].fall) begin
                pwm_c[i] = (bus.time_cnt >= active[i].rise) && (bus.time_cnt < active[i].fall);
            end else begin
                pwm_c[i] = (bus.time_cnt >= active[i].rise) || (bus.time_cnt < active[i].fall);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx     <= '0;
            shadow_full  <= 1'b0;
            shadow_mode  <= 1'b0;
            dout_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
            pwm_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= EDGES_RST;
                active[i] <= EDGES_RST;
            end
        end else begin
            load_idx     <= load_idx_n;
            shadow_full  <= shadow_full_n;
            dout_valid_q <= commit;
            load_err_q   <= frame_err;
            pwm_q        <= pwm_c;
            if (bus.din_valid) begin
                shadow[load_idx] <= beat;
                if (load_idx == '0) begin
                    shadow_mode <= bus.mode;
                end
            end
            // Parallel copy; a final beat arriving with update bypasses the shadow.
            if (commit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    active[i] <= shadow[i];
                end
                if (last_beat) begin
                    active[LAST_IDX] <= beat;
                end
            end
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.load_err   = load_err_q;
endmodule
